pipe_demux: RTL and testbench

- Registered 1-to-2 demultiplexer for the MIPS pipeline. It is the inverse of the 2:1 operand mux.
- It takes one 32-bit result stream plus a 1-bit select and steers each word to exactly one of two downstream consumers, for example the forwarding path and the write-back path.
- Each output is buffered by its own small FIFO, so one stalled consumer does not block words headed to the other consumer while that consumer's slot has space.
- All data transfers use valid/ready handshakes.

---
 rtl/pipe_demux_pkg.sv | 6 +
 rtl/demux_fifo.sv | 37 +++
 rtl/pipe_demux.sv | 46 ++++
 tb/tb_pipe_demux.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_demux_pkg.sv
// pipe_demux_pkg: shared widths and select encodings for the result-stream demux.
package pipe_demux_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = 16;
  typedef enum logic {SEL_OUT1 = 1'b0, SEL_OUT2 = 1'b1} sel_e;
endpackage

// File: rtl/demux_fifo.sv
// demux_fifo: DEPTH-entry synchronous FIFO with wrap-bit pointers; head holds the last word when empty.
module demux_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr;
  logic [AW-1:0] last_idx;
  logic [WIDTH-1:0] mem [DEPTH];
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = wptr == rptr;
  // When drained, the most recently popped slot sits just behind the read pointer.
  assign last_idx = rptr[AW-1:0] - AW'(1);
  assign head = mem[empty ? last_idx : rptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr <= wptr + 1'b1;
      end
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/pipe_demux.sv
// pipe_demux: registered 1-to-2 valid/ready demux with a FIFO per output; PIPE_DEMUX_COUNT_EN adds accept counters.
module pipe_demux
  import pipe_demux_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready
`ifdef PIPE_DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
`endif
);
  logic full1, full2, empty1, empty2, push1, push2;
  assign in_ready = !reset && !(in_sel == SEL_OUT2 ? full2 : full1);
  assign push1 = in_valid && in_ready && in_sel == SEL_OUT1;
  assign push2 = in_valid && in_ready && in_sel == SEL_OUT2;
  assign out1_valid = !empty1;
  assign out2_valid = !empty2;
  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset), .push(push1), .push_data(in_data), .pop(out1_ready),
    .full(full1), .empty(empty1), .head(out1_data)
  );
  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
    .clk(clk), .reset(reset), .push(push2), .push_data(in_data), .pop(out2_ready),
    .full(full2), .empty(empty2), .head(out2_data)
  );
`ifdef PIPE_DEMUX_COUNT_EN
  always_ff @(posedge clk) begin
    cnt1 <= reset ? '0 : cnt1 + CNT_W'(push1);
    cnt2 <= reset ? '0 : cnt2 + CNT_W'(push2);
  end
`endif
endmodule

// File: tb/tb_pipe_demux.sv
// tb_pipe_demux: directed scoreboard bench for pipe_demux.
module tb_pipe_demux;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] in_data = '0;
  logic in_sel = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] out1_data, out2_data;
  logic out1_valid, out2_valid;
  logic out1_ready = 1'b1;
  logic out2_ready = 1'b1;
`ifdef PIPE_DEMUX_COUNT_EN
  logic [15:0] cnt1, cnt2;
`endif
  int total = 0;
  int bad = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic stall = 1'b0;
  logic ps;
  logic [31:0] pd;

  pipe_demux dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready)
`ifdef PIPE_DEMUX_COUNT_EN
    , .cnt1(cnt1), .cnt2(cnt2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d);
    in_valid = v;
    in_sel = s;
    in_data = d;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q1.delete();
      q2.delete();
      stall = 1'b0;
    end else begin
      if (stall && in_valid) begin
        chk("stable_data", in_data, pd);
        chk("stable_sel", 32'(in_sel), 32'(ps));
      end
      if (out1_valid && out1_ready) begin
        chk("out1_sb_nonempty", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) chk("out1_order", out1_data, q1.pop_front());
      end
      if (out2_valid && out2_ready) begin
        chk("out2_sb_nonempty", 32'(q2.size() != 0), 32'd1);
        if (q2.size() != 0) chk("out2_order", out2_data, q2.pop_front());
      end
      if (in_valid && in_ready) begin
        if (in_sel) q2.push_back(in_data);
        else q1.push_back(in_data);
      end
      stall = in_valid && !in_ready;
      pd = in_data;
      ps = in_sel;
    end
  end

  initial begin
    step;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step;
    reset = 1'b0;
    #1;
    chk("rst_in_ready_rel", 32'(in_ready), 32'd1);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out2_valid", 32'(out2_valid), 32'd0);
    chk("rst_out1_data", out1_data, 32'd0);
    chk("rst_out2_data", out2_data, 32'd0);
    drive(1, 0, 30);
    step;
    chk("route_out1_valid", 32'(out1_valid), 32'd1);
    chk("route_out1_data", out1_data, 32'd30);
    drive(1, 1, 0);
    step;
    drive(0, 0, 0);
    chk("route_out2_valid", 32'(out2_valid), 32'd1);
    chk("route_out2_data", out2_data, 32'd0);
    chk("route_out1_drained", 32'(out1_valid), 32'd0);
    chk("route_out1_hold", out1_data, 32'd30);
    step;
    out1_ready = 1'b0;
    drive(1, 0, 1);
    step;
    drive(1, 0, 2);
    step;
    drive(1, 0, 3);
    #1 chk("bp_full_ready", 32'(in_ready), 32'd0);
    step;
    chk("bp_full_ready2", 32'(in_ready), 32'd0);
    chk("bp_head", out1_data, 32'd1);
    chk("bp_head_valid", 32'(out1_valid), 32'd1);
    drive(0, 0, 0);
    step;
    drive(1, 1, 40);
    #1 chk("iso_ready_a", 32'(in_ready), 32'd1);
    step;
    drive(1, 1, 41);
    #1 chk("iso_ready_b", 32'(in_ready), 32'd1);
    step;
    chk("iso_out2_data", out2_data, 32'd41);
    drive(1, 0, 3);
    out1_ready = 1'b1;
    #1 chk("bp_pop_full_ready", 32'(in_ready), 32'd0);
    step;
    chk("bp_space_ready", 32'(in_ready), 32'd1);
    chk("bp_head2", out1_data, 32'd2);
    step;
    drive(0, 0, 0);
    chk("bp_head3", out1_data, 32'd3);
    step;
    for (int i = 0; i < 100; i++) begin
      drive(1, i[0], 1000 + i);
      #1 chk("tp_ready", 32'(in_ready), 32'd1);
      step;
      if (i[0]) begin
        chk("tp_out2_valid", 32'(out2_valid), 32'd1);
        chk("tp_out2_data", out2_data, 32'(1000 + i));
      end else begin
        chk("tp_out1_valid", 32'(out1_valid), 32'd1);
        chk("tp_out1_data", out1_data, 32'(1000 + i));
      end
    end
    drive(0, 0, 0);
    step;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    drive(1, 0, 10); step;
    drive(1, 0, 11); step;
    drive(1, 1, 20); step;
    drive(1, 1, 21); step;
    drive(0, 0, 0);
    chk("mid_full1", 32'(out1_valid), 32'd1);
    step;
    drive(1, 0, 77);
    reset = 1'b1;
    #1 chk("mid_rst_ready", 32'(in_ready), 32'd0);
    step;
    reset = 1'b0;
    drive(0, 0, 0);
    #1;
    chk("mid_out1_valid", 32'(out1_valid), 32'd0);
    chk("mid_out2_valid", 32'(out2_valid), 32'd0);
    chk("mid_out1_data", out1_data, 32'd0);
    chk("mid_out2_data", out2_data, 32'd0);
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    drive(1, 0, 55);
    step;
    drive(0, 0, 0);
    chk("mid_first_valid", 32'(out1_valid), 32'd1);
    chk("mid_first_data", out1_data, 32'd55);
    step;
`ifdef PIPE_DEMUX_COUNT_EN
    reset = 1'b1;
    step;
    reset = 1'b0;
    #1;
    chk("cnt1_rst", 32'(cnt1), 32'd0);
    drive(1, 0, 0);
    for (int i = 0; i < 65537; i++) begin
      in_data = i;
      step;
    end
    drive(0, 0, 0);
    chk("cnt1_wrap", 32'(cnt1), 32'd1);
    chk("cnt2_zero", 32'(cnt2), 32'd0);
    step;
`endif
    step;
    step;
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    chk("sb2_drained", 32'(q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
